// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM symbol encoder.
package pwm_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, MARK, SPACE, GUARD} state_t;

  localparam logic signed [15:0] DEF_AMPLITUDE  = 16'sd280;
  localparam int                 DEF_SYNC_LEN   = 4;
  localparam int                 DEF_UNIT_LEN   = 4;
  localparam int                 DEF_MAX_SYMBOL = 15;
  localparam int                 DEF_GUARD_LEN  = 8;

  // Frame length in samples; constant for every symbol.
  function automatic int frame_len(input int sync_len, input int unit_len,
                                   input int max_symbol, input int guard_len);
    return sync_len + (max_symbol + 2) * unit_len + guard_len;
  endfunction

endpackage

// File: rtl/pwm_segment_counter.sv
// Down-counter for segment length: load length-1, step on dec, done at zero.
module pwm_segment_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         done
);

  assign done = (count == '0);

  // Saturates at zero instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          count <= '0;
    else if (load)         count <= load_val;
    else if (dec && !done) count <= count - 1'b1;
  end

endmodule

// File: rtl/pwm_symbol_encoder.sv
// PWM symbol encoder: SYNC / MARK / SPACE / GUARD frame per accepted symbol.
// Optional PWM_ENC_SOFT_EDGE_EN halves the first sample of each non-guard segment.
module pwm_symbol_encoder
  import pwm_pkg::*;
#(
  parameter logic signed [15:0] AMPLITUDE  = DEF_AMPLITUDE,
  parameter int                 SYNC_LEN   = DEF_SYNC_LEN,
  parameter int                 UNIT_LEN   = DEF_UNIT_LEN,
  parameter int                 MAX_SYMBOL = DEF_MAX_SYMBOL,
  parameter int                 GUARD_LEN  = DEF_GUARD_LEN
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [7:0]         symbol_in,
  input  logic               symbol_valid,
  output logic               symbol_ready,
  output logic signed [15:0] data_out,
  output logic               data_valid,
  output logic               sat_flag
);

  localparam logic signed [15:0] POS = AMPLITUDE;
  localparam logic signed [15:0] NEG = -AMPLITUDE;
`ifdef PWM_ENC_SOFT_EDGE_EN
  localparam logic signed [15:0] POS_EDGE = POS >>> 1;
  localparam logic signed [15:0] NEG_EDGE = NEG >>> 1;
`else
  localparam logic signed [15:0] POS_EDGE = POS;
  localparam logic signed [15:0] NEG_EDGE = NEG;
`endif
  localparam logic [15:0] SYNC_M1  = 16'(SYNC_LEN - 1);
  localparam logic [15:0] GUARD_M1 = 16'(GUARD_LEN - 1);

  state_t             state, next_state;
  logic [7:0]         sym;
  logic               accept, clamp;
  logic [7:0]         sym_clamped;
  logic [15:0]        mark_m1, space_m1, load_val, count;
  logic               load, dec, done;
  logic signed [15:0] next_data;
  logic               next_valid;

  assign symbol_ready = (state == IDLE) && enable;
  assign accept       = symbol_valid && symbol_ready;
  assign clamp        = int'(symbol_in) > MAX_SYMBOL;
  assign sym_clamped  = clamp ? 8'(MAX_SYMBOL) : symbol_in;

  // Lengths computed at 32 bits, then narrowed to the counter width.
  assign mark_m1  = 16'((int'(sym) + 1) * UNIT_LEN - 1);
  assign space_m1 = 16'((MAX_SYMBOL - int'(sym) + 1) * UNIT_LEN - 1);

  pwm_segment_counter #(.W(16)) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .count    (count),
    .done     (done)
  );

  // state tags the segment of the sample currently on data_out.
  always_comb begin
    next_state = state;
    next_data  = data_out;
    next_valid = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    dec        = 1'b0;
    if (enable) begin
      next_valid = 1'b1;
      unique case (state)
        IDLE: begin
          next_data = '0;
          if (accept) begin
            next_state = SYNC;
            load       = 1'b1;
            load_val   = SYNC_M1;
            next_data  = NEG_EDGE;
          end else begin
            next_valid = 1'b0;
          end
        end
        SYNC: begin
          if (done) begin
            next_state = MARK;
            load       = 1'b1;
            load_val   = mark_m1;
            next_data  = POS_EDGE;
          end else begin
            dec       = 1'b1;
            next_data = NEG;
          end
        end
        MARK: begin
          if (done) begin
            next_state = SPACE;
            load       = 1'b1;
            load_val   = space_m1;
            next_data  = NEG_EDGE;
          end else begin
            dec       = 1'b1;
            next_data = POS;
          end
        end
        SPACE: begin
          if (done) begin
            next_state = GUARD;
            load       = 1'b1;
            load_val   = GUARD_M1;
          end else begin
            dec = 1'b1;
          end
          next_data = done ? 16'sd0 : NEG;
        end
        GUARD: begin
          next_data = '0;
          if (done) begin
            next_state = IDLE;
            next_valid = 1'b0;
          end else begin
            dec = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
          next_data  = '0;
          next_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      data_out   <= '0;
      data_valid <= 1'b0;
      sat_flag   <= 1'b0;
      sym        <= '0;
    end else begin
      state      <= next_state;
      data_out   <= next_data;
      data_valid <= next_valid;
      sat_flag   <= accept && clamp;
      if (accept) sym <= sym_clamped;
    end
  end

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// Directed bench for pwm_symbol_encoder; expected frames hand-derived from defaults.
module tb_pwm_symbol_encoder;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               enable;
  logic [7:0]         symbol_in;
  logic               symbol_valid;
  logic               symbol_ready;
  logic signed [15:0] data_out;
  logic               data_valid;
  logic               sat_flag;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [15:0] q[$];

  always #5 clock = ~clock;

  pwm_symbol_encoder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .symbol_in    (symbol_in),
    .symbol_valid (symbol_valid),
    .symbol_ready (symbol_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .sat_flag     (sat_flag)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Sends one symbol and collects 80 samples; exp_mark/exp_space are hand-computed.
  task automatic send(input logic [7:0] sym, input bit toggle,
                      input int exp_mark, input int exp_space, input int exp_sat);
    logic signed [15:0] e[$];
    int sat_cnt = 0, bad_vld = 0, mism = 0, npos = 0, nneg = 0;
    bit prev_en = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++)         e.push_back(-16'sd280);
    for (int i = 0; i < exp_mark; i++)  e.push_back(16'sd280);
    for (int i = 0; i < exp_space; i++) e.push_back(-16'sd280);
    for (int i = 0; i < 8; i++)         e.push_back(16'sd0);
`ifdef PWM_ENC_SOFT_EDGE_EN
    e[0] = -16'sd140;
    e[4] = 16'sd140;
    e[4 + exp_mark] = -16'sd140;
`endif
    @(negedge clock);
    enable = 1'b1; symbol_in = sym; symbol_valid = 1'b1;
    chk("ready_idle", int'(symbol_ready), 1);
    @(negedge clock);
    symbol_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (data_valid) q.push_back(data_out);
      if (data_valid && !prev_en) bad_vld++;
      if (sat_flag) sat_cnt++;
      if (q.size() >= 80) break;
      if (toggle) enable = ~enable;
      prev_en = enable;
      @(negedge clock);
    end
    chk("frame_len", q.size(), 80);
    foreach (q[i]) begin
      if (i < e.size() && q[i] !== e[i]) mism++;
      if (q[i] > 0) npos++;
      if (q[i] < 0) nneg++;
    end
    chk("sample_mism", mism, 0);
    chk("mark_len", npos, exp_mark);
    chk("space_len", nneg - 4, exp_space);
    chk("sat_cnt", sat_cnt, exp_sat);
    chk("valid_gating", bad_vld, 0);
    enable = 1'b1;
    chk("ready_last_guard", int'(symbol_ready), 0);
    @(negedge clock);
    chk("ready_back", int'(symbol_ready), 1);
    chk("idle_valid", int'(data_valid), 0);
    chk("idle_data", int'(data_out), 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; symbol_in = '0; symbol_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_data", int'(data_out), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_ready_en0", int'(symbol_ready), 0);
    reset_n = 1'b1;

    // valid without ready is dropped
    symbol_in = 8'd5; symbol_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk("noready_valid", int'(data_valid), 0);
    symbol_valid = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    #1 chk("ready_en1", int'(symbol_ready), 1);
    @(negedge clock);
    chk("noready_still_idle", int'(data_valid), 0);

    send(8'd11,  1'b0, 48, 20, 0);
    send(8'd0,   1'b0, 4,  64, 0);
    send(8'd15,  1'b0, 64, 4,  0);
    send(8'd200, 1'b0, 64, 4,  1);
    send(8'd11,  1'b1, 48, 20, 0);

    // reset at MARK sample 10 (frame sample 14)
    @(negedge clock);
    enable = 1'b1; symbol_in = 8'd11; symbol_valid = 1'b1;
    @(negedge clock);
    symbol_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (data_valid) n++;
      if (n >= 14) break;
      @(negedge clock);
    end
    chk("pre_rst_samples", n, 14);
    chk("pre_rst_level", int'(data_out), 280);
    reset_n = 1'b0;
    #1;
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_valid", int'(data_valid), 0);
    chk("midrst_ready", int'(symbol_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_valid", int'(data_valid), 0);
    send(8'd11, 1'b0, 48, 20, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_symbol_encoder.md
PWM_SYMBOL_ENCODER -- requirements
Module: pwm_symbol_encoder

Interface
REQ-001 SHALL have parameter AMPLITUDE, default 16'sd280, the signed pulse level.
REQ-002 SHALL have parameter SYNC_LEN, default 4, the sync segment length in samples (>=1).
REQ-003 SHALL have parameter UNIT_LEN, default 4, the samples per symbol step (>=1).
REQ-004 SHALL have parameter MAX_SYMBOL, default 15, the largest encodable symbol.
REQ-005 SHALL have parameter GUARD_LEN, default 8, the zero-level gap in samples after each frame (>=1).
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic rises on it.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: sample-advance qualifier.
REQ-009 SHALL have port symbol_in, input, 8 bits unsigned: the symbol to transmit.
REQ-010 SHALL have port symbol_valid, input, 1 bit: symbol_in is valid.
REQ-011 SHALL have port symbol_ready, output, 1 bit: the encoder accepts a symbol this cycle.
REQ-012 SHALL have port data_out, output, signed 16 bits: the PWM sample stream.
REQ-013 SHALL have port data_valid, output, 1 bit: data_out holds a new sample.
REQ-014 SHALL have port sat_flag, output, 1 bit: one-cycle pulse when an accepted symbol was clamped.

Function
REQ-015 SHALL implement FSM states IDLE, SYNC, MARK, SPACE and GUARD.
REQ-016 SHALL drive symbol_ready = (state==IDLE) && enable.
- Accept = symbol_valid && symbol_ready.
- symbol_valid without ready SHALL be ignored; no buffering.
REQ-017 On accept, SHALL latch symbol_in, clamped to MAX_SYMBOL if larger.
- sat_flag SHALL be 1 in the following cycle if clamping occurred.
- Next state is SYNC.
- The first sample appears one cycle after accept.
REQ-018 SYNC SHALL output -AMPLITUDE for SYNC_LEN samples.
REQ-019 MARK SHALL output +AMPLITUDE for (sym+1)*UNIT_LEN samples.
REQ-020 SPACE SHALL output -AMPLITUDE for (MAX_SYMBOL-sym+1)*UNIT_LEN samples.
REQ-021 GUARD SHALL output 0 for GUARD_LEN samples, then return to IDLE.
- Total frame = SYNC_LEN + (MAX_SYMBOL+2)*UNIT_LEN + GUARD_LEN samples, independent of the symbol.
REQ-022 A sample SHALL advance only on cycles with enable=1.
- With enable=0, state, counter and data_out SHALL hold and data_valid SHALL be 0.
REQ-023 data_valid SHALL be 1 for each registered sample emitted in SYNC through GUARD.
- data_valid SHALL be 0 in IDLE, where data_out = 0.
REQ-024 The segment counter SHALL be 16 bits.
- It loads length-1 at segment entry and transitions at 0; no wrap-around is permitted.
- Products SHALL be computed at 16 bits or wider.

Reset
REQ-025 On reset_n=0, the encoder SHALL asynchronously enter IDLE and drive data_out=0, data_valid=0, sat_flag=0 and counter=0.
- symbol_ready SHALL follow REQ-016.
- A reset mid-frame SHALL abort the frame with no residual samples.

Configuration
REQ-026 With PWM_ENC_SOFT_EDGE_EN defined, the first sample of each SYNC, MARK and SPACE segment SHALL be the segment level arithmetically shifted right by 1; timing is unchanged.
- Without the macro, all segment samples SHALL be full level.

Structure
REQ-027 A shared package pwm_pkg SHALL hold:
- the FSM state enum;
- default AMPLITUDE, SYNC_LEN, UNIT_LEN, MAX_SYMBOL and GUARD_LEN constants;
- the frame-length function.
REQ-028 A single sub-module pwm_segment_counter (load, decrement on enable, done flag) SHALL be natural; the FSM and datapath stay in the top level.

Verification
REQ-029 Defaults, symbol 11, enable held 1 -> 4×(-280), 48×(+280), 20×(-280), 8×0; 80 valid samples; ready returns 1 cycle after the last guard sample.
REQ-030 Symbol 0, then symbol 15 -> MARK 4 / SPACE 64, then MARK 64 / SPACE 4; each frame 80 samples.
REQ-031 Symbol 200 -> sat_flag pulses once; encoded as 15.
REQ-032 enable toggled 1-0 every cycle during a symbol 11 frame -> identical sample sequence; data_valid only on enable=1 cycles.
REQ-033 reset_n low at MARK sample 10 -> data_out=0, data_valid=0 immediately; after release, ready=1 and the next symbol gives a full frame.
REQ-034 With PWM_ENC_SOFT_EDGE_EN defined, symbol 11 -> first samples of the segments are -140, +140, -140; length 80.
